// File: rtl/im2_sched_if.sv
// im2_sched_if: host/im2/accumulator-side signals of the im2col loop scheduler
interface im2_sched_if #(
  parameter int MAX_Y1 = 32,
  parameter int MAX_Y2 = 32,
  parameter int CNT_W  = 16
);
  localparam int JW = $clog2(MAX_Y1) + 1;
  localparam int IW = $clog2(MAX_Y2) + 1;
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] num_n;
  logic [IW-1:0]    out_h;
  logic [JW-1:0]    out_w;
  logic [CNT_W-1:0] num_kgrp;
  logic             im2_done;
  logic             en_im2;
  logic [CNT_W-1:0] n;
  logic [CNT_W-1:0] k_grp;
  logic [IW-1:0]    patch_i;
  logic [JW-1:0]    patch_j;
  logic             first_kgrp;
  logic             patch_valid;
  logic             patch_ready;
  logic             busy;
  logic             layer_done;
  modport master (
    output start, abort, num_n, out_h, out_w, num_kgrp, im2_done, patch_ready,
    input  en_im2, n, k_grp, patch_i, patch_j, first_kgrp, patch_valid, busy, layer_done
  );
  modport slave (
    input  start, abort, num_n, out_h, out_w, num_kgrp, im2_done, patch_ready,
    output en_im2, n, k_grp, patch_i, patch_j, first_kgrp, patch_valid, busy, layer_done
  );
endinterface

// File: rtl/im2_sched.sv
// im2_sched: nested n/patch_i/patch_j/k_grp loop controller strobing the im2col generator
module im2_sched #(
  parameter int MAX_Y1 = 32,
  parameter int MAX_Y2 = 32,
  parameter int CNT_W  = 16
) (
  input logic clk,
  input logic rst,
  im2_sched_if.slave bus
);
  localparam int JW = $clog2(MAX_Y1) + 1;
  localparam int IW = $clog2(MAX_Y2) + 1;
  typedef enum logic [2:0] {IDLE, RUN, GAP, FLUSH, FIN} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] n_m1, kg_m1, n_nx, kg_nx;
  logic [IW-1:0] h_m1, i_nx;
  logic [JW-1:0] w_m1, j_nx;
  logic fresh, zero_cfg, last_kg, j_wrap, i_wrap, last_patch, go, adv_k, adv_p;
  always_comb begin
    zero_cfg = bus.num_n == '0 || bus.out_h == '0 || bus.out_w == '0 || bus.num_kgrp == '0;
    last_kg = bus.k_grp == kg_m1;
    j_wrap = bus.patch_j == w_m1;
    i_wrap = bus.patch_i == h_m1;
    last_patch = j_wrap && i_wrap && bus.n == n_m1;
  end
  // fresh masks a done left over from the previous chunk on the first RUN cycle
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = bus.start ? (zero_cfg ? FIN : RUN) : IDLE;
      RUN:     state_nx = bus.im2_done && !fresh ? GAP : RUN;
      GAP:     state_nx = last_kg ? FLUSH : RUN;
      FLUSH:   state_nx = bus.patch_ready ? (last_patch ? FIN : RUN) : FLUSH;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (bus.abort) state_nx = IDLE;
  end
  always_comb begin
    go = state == IDLE && state_nx != IDLE;
    adv_k = state == GAP && state_nx == RUN;
    adv_p = state == FLUSH && state_nx == RUN;
    kg_nx = go || adv_p ? '0 : adv_k ? bus.k_grp + 1'b1 : bus.k_grp;
    j_nx = go || (adv_p && j_wrap) ? '0 : adv_p ? bus.patch_j + 1'b1 : bus.patch_j;
    i_nx = go || (adv_p && j_wrap && i_wrap) ? '0 : adv_p && j_wrap ? bus.patch_i + 1'b1 : bus.patch_i;
    n_nx = go ? '0 : adv_p && j_wrap && i_wrap ? bus.n + 1'b1 : bus.n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      fresh <= 1'b0;
      n_m1 <= '0;
      kg_m1 <= '0;
      h_m1 <= '0;
      w_m1 <= '0;
      bus.en_im2 <= 1'b0;
      bus.n <= '0;
      bus.k_grp <= '0;
      bus.patch_i <= '0;
      bus.patch_j <= '0;
      bus.first_kgrp <= 1'b1;
      bus.patch_valid <= 1'b0;
      bus.busy <= 1'b0;
      bus.layer_done <= 1'b0;
    end else begin
      state <= state_nx;
      fresh <= state_nx == RUN && state != RUN;
      if (go) begin
        n_m1 <= bus.num_n - 1'b1;
        kg_m1 <= bus.num_kgrp - 1'b1;
        h_m1 <= bus.out_h - 1'b1;
        w_m1 <= bus.out_w - 1'b1;
      end
      bus.en_im2 <= state_nx == RUN;
      bus.n <= n_nx;
      bus.k_grp <= kg_nx;
      bus.patch_i <= i_nx;
      bus.patch_j <= j_nx;
      bus.first_kgrp <= kg_nx == '0;
      bus.patch_valid <= state_nx == FLUSH;
      bus.busy <= state_nx != IDLE;
      bus.layer_done <= state_nx == FIN;
    end
  end
endmodule
